pipe_hazard_ctrl: RTL

- Central stall/flush controller for the 5-stage MIPS pipeline.
- Handles three cases:
  - load-use hazards between EX and ID;
  - multi-cycle MULT/DIV occupancy of HI/LO;
  - precise exception/ERET redirect from the MEM stage.
- Drives the stall/flush inputs of the IF/ID, ID/EX and EX/MEM stage registers, the PC.
- Drives the cp0bubble kill input of the MEM/WB register (value 3 clears the WB-stage cp0op).

---
 rtl/pipe_hazard_ctrl.sv | 95 +++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: load-use/MDU stall and MEM-stage exception flush control; PIPE_HAZARD_CTRL_PERF_EN adds stall_cnt/flush_cnt.
module pipe_hazard_ctrl #(
    parameter int MULT_LAT = 4,
    parameter int DIV_LAT  = 32,
    parameter int CNT_W    = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [4:0]   id_rs,
    input  logic [4:0]   id_rt,
    input  logic         id_use_rt,
    input  logic         id_mdu_read,
    input  logic [4:0]   ex_rw,
    input  logic         ex_regWr,
    input  logic [1:0]   ex_memtoreg,
    input  logic         ex_mdu_start,
    input  logic         ex_mdu_div,
    input  logic         mem_exc,
    input  logic         mem_eret,
    output logic         pc_stall,
    output logic         if_id_stall,
    output logic         if_id_flush,
    output logic         id_ex_flush,
    output logic         ex_mem_flush,
    output logic         pc_sel_exc,
    output logic         mdu_busy,
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    output logic [1:0]   cp0bubble,
    output logic [31:0]  stall_cnt,
    output logic [31:0]  flush_cnt
`else
    output logic [1:0]   cp0bubble
`endif
);
    localparam logic [1:0] RUN       = 2'd0;
    localparam logic [1:0] MDU_BUSY  = 2'd1;
    localparam logic [1:0] EXC_FLUSH = 2'd2;
    localparam logic [CNT_W-1:0] MUL_LD = CNT_W'(MULT_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LD = CNT_W'(DIV_LAT - 1);

    logic [1:0]       state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n, ld;
    logic             active, lu, exc, stall, flushing;

    always_comb begin
        active   = ~rst & (state != EXC_FLUSH);
        flushing = ~rst & (state == EXC_FLUSH);
        lu       = ex_regWr & (ex_memtoreg == 2'b01) & (ex_rw != 5'd0) &
                   ((ex_rw == id_rs) | (id_use_rt & (ex_rw == id_rt)));
        exc      = active & (mem_exc | mem_eret);
        // exception redirect overrides every stall source
        stall    = active & ~exc & (lu | ((state == MDU_BUSY) & id_mdu_read));
        ld       = ex_mdu_div ? DIV_LD : MUL_LD;
        state_n  = (state == EXC_FLUSH) ? RUN :
                   exc ? EXC_FLUSH :
                   ((state == RUN) & ex_mdu_start & (ld != '0)) ? MDU_BUSY :
                   ((state == MDU_BUSY) & (cnt == CNT_W'(1))) ? RUN : state;
        cnt_n    = ((state == EXC_FLUSH) | exc) ? '0 :
                   ((state == RUN) & ex_mdu_start) ? ld :
                   (state == MDU_BUSY) ? cnt - CNT_W'(1) : cnt;
    end

    assign pc_stall     = stall;
    assign if_id_stall  = stall;
    assign id_ex_flush  = stall | exc;
    assign ex_mem_flush = exc;
    assign pc_sel_exc   = exc;
    assign if_id_flush  = exc | flushing;
    assign mdu_busy     = ~rst & (cnt != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            cnt       <= '0;
            cp0bubble <= 2'b00;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            cp0bubble <= exc ? 2'b11 : 2'b00;
        end
    end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            stall_cnt <= stall_cnt + {31'd0, stall};
            flush_cnt <= flush_cnt + {31'd0, exc};
        end
    end
`else
`endif
endmodule
